// File: rtl/square_wave_pkg.sv
// rtl/square_wave_pkg.sv - shared constants and helpers for the square-wave input conditioner
package square_wave_pkg;

  localparam int SYS_CLK_FREQ    = 50_000_000;
  localparam int PLL_FREQ        = 200_000_000;
  localparam int CH_NUM          = 2;
  localparam int FILT_LEN_DEF    = 4;
  localparam int TIMEOUT_CYC_DEF = 5_000_000;
  localparam int GLITCH_W_DEF    = 8;

  // Bits needed to hold values 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/square_wave_cond_ch.sv
// rtl/square_wave_cond_ch.sv - one channel: synchroniser, glitch filter, edge strobes, timeout, glitch stats
module square_wave_cond_ch
  import square_wave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = FILT_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int GLITCH_W    = GLITCH_W_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                wave_in,
  input  logic                clr_stat,
  output logic                wave_clean,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                sig_valid,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int FW = cnt_w(FILT_LEN);
  localparam int TW = cnt_w(TIMEOUT_CYC);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TIME_MAX = TW'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          filt_cnt;
  logic [TW-1:0]          time_cnt;
  logic                   sync;
  logic                   differ;
  logic                   commit;
  logic                   glitch;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    differ = 1'b0;
    commit = 1'b0;
    glitch = 1'b0;
    differ = (sync != wave_clean);
    commit = differ && (filt_cnt == FILT_MAX);
    // A partially qualified change that falls back counts as one rejected glitch.
    glitch = !differ && (filt_cnt != '0);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q     <= '0;
      filt_cnt   <= '0;
      wave_clean <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], wave_in};
      rise_pulse <= commit && sync;
      fall_pulse <= commit && !sync;
      if (commit) begin
        wave_clean <= sync;
        filt_cnt   <= '0;
      end else if (differ) begin
        filt_cnt <= filt_cnt + 1'b1;
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // The counter parks at TIME_MAX so a dead input never wraps back to valid.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      time_cnt  <= '0;
      sig_valid <= 1'b0;
    end else if (commit) begin
      time_cnt  <= '0;
      sig_valid <= 1'b1;
    end else if (time_cnt == TIME_MAX) begin
      sig_valid <= 1'b0;
    end else begin
      time_cnt <= time_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      glitch_cnt <= '0;
    end else if (clr_stat) begin
      glitch_cnt <= '0;
    end else if (glitch && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/square_wave_cond.sv
// rtl/square_wave_cond.sv - multi-channel square-wave input conditioner feeding the measurement stage
module square_wave_cond #(
  parameter int CH_NUM      = square_wave_pkg::CH_NUM,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = square_wave_pkg::FILT_LEN_DEF,
  parameter int TIMEOUT_CYC = square_wave_pkg::TIMEOUT_CYC_DEF,
  parameter int GLITCH_W    = square_wave_pkg::GLITCH_W_DEF
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [CH_NUM-1:0]          wave_in,
  input  logic                       clr_stat,
  output logic [CH_NUM-1:0]          wave_clean,
  output logic [CH_NUM-1:0]          rise_pulse,
  output logic [CH_NUM-1:0]          fall_pulse,
  output logic [CH_NUM-1:0]          sig_valid,
  output logic [CH_NUM*GLITCH_W-1:0] glitch_cnt
);

  import square_wave_pkg::*;

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_ch
    square_wave_cond_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .GLITCH_W    (GLITCH_W)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .wave_in    (wave_in[ch]),
      .clr_stat   (clr_stat),
      .wave_clean (wave_clean[ch]),
      .rise_pulse (rise_pulse[ch]),
      .fall_pulse (fall_pulse[ch]),
      .sig_valid  (sig_valid[ch]),
      .glitch_cnt (glitch_cnt[ch*GLITCH_W +: GLITCH_W])
    );
  end

endmodule

// File: tb/tb_square_wave_cond.sv
// tb/tb_square_wave_cond.sv - self-checking bench for square_wave_cond
module tb_square_wave_cond;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] wave_in;
  logic       clr_stat;
  logic [1:0] wave_clean;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;
  logic [1:0] sig_valid;
  logic [7:0] glitch_cnt;

  square_wave_cond #(
    .CH_NUM      (2),
    .SYNC_STAGES (2),
    .FILT_LEN    (4),
    .TIMEOUT_CYC (100),
    .GLITCH_W    (4)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wave_in    (wave_in),
    .clr_stat   (clr_stat),
    .wave_clean (wave_clean),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .sig_valid  (sig_valid),
    .glitch_cnt (glitch_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int   ch;
    int   at;
    logic rise;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    logic [1:0] in;
    logic       qual;
    int         n;
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] valid;
    logic [7:0] glitch;
  } vec_t;
  vec_t tbl[7];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // A qualifying input step must strobe exactly SYNC_STAGES+FILT_LEN edges later.
  task automatic drive(input logic [1:0] v, input logic qual);
    for (int ch = 0; ch < 2; ch++)
      if (qual && (v[ch] != wave_in[ch])) evq.push_back('{ch, cyc + 6, v[ch]});
    wave_in = v;
  endtask

  task automatic do_reset();
    wave_in  = 2'b00;
    clr_stat = 1'b0;
    sys_rst  = 1'b1;
    tick();
    sys_rst  = 1'b0;
  endtask

  // Strobe scoreboard: every strobe must match the oldest expectation for its channel.
  always begin
    int idx;
    @(posedge sys_clk);
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      if (rise_pulse[ch] || fall_pulse[ch]) begin
        n_vec++;
        idx = -1;
        for (int i = 0; i < evq.size(); i++)
          if (idx < 0 && evq[i].ch == ch) idx = i;
        if (rise_pulse[ch] && fall_pulse[ch]) begin
          n_err++;
          $display("FAIL strobe_both ch%0d: rise and fall together at cycle %0d", ch, cyc);
        end else if (idx < 0) begin
          n_err++;
          $display("FAIL strobe_unexpected ch%0d: rise=%0b fall=%0b at cycle %0d expected none",
                   ch, rise_pulse[ch], fall_pulse[ch], cyc);
        end else begin
          if (evq[idx].at != cyc || evq[idx].rise != rise_pulse[ch]) begin
            n_err++;
            $display("FAIL strobe_timing ch%0d: got rise=%0b at cycle %0d expected rise=%0b at cycle %0d",
                     ch, rise_pulse[ch], cyc, evq[idx].rise, evq[idx].at);
          end
          evq.delete(idx);
        end
      end
    end
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].at < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL strobe_missing ch%0d: got none expected rise=%0b at cycle %0d",
                 evq[i].ch, evq[i].rise, evq[i].at);
        evq.delete(i);
      end
    end
  end

  int t;
  int last_fall;

  initial begin
    //          in     qual  n   clean  rise   fall   valid  glitch
    tbl[0] = '{2'b00, 1'b0, 50, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00};
    tbl[1] = '{2'b01, 1'b1, 5,  2'b00, 2'b00, 2'b00, 2'b00, 8'h00};
    tbl[2] = '{2'b01, 1'b0, 1,  2'b01, 2'b01, 2'b00, 2'b01, 8'h00};
    tbl[3] = '{2'b01, 1'b0, 1,  2'b01, 2'b00, 2'b00, 2'b01, 8'h00};
    tbl[4] = '{2'b11, 1'b0, 3,  2'b01, 2'b00, 2'b00, 2'b01, 8'h00};
    tbl[5] = '{2'b01, 1'b0, 2,  2'b01, 2'b00, 2'b00, 2'b01, 8'h00};
    tbl[6] = '{2'b01, 1'b0, 1,  2'b01, 2'b00, 2'b00, 2'b01, 8'h10};

    sys_rst  = 1'b1;
    wave_in  = 2'b00;
    clr_stat = 1'b0;
    tick();
    tick();
    chk("rst_clean", wave_clean, 2'b00);
    chk("rst_rise", rise_pulse, 2'b00);
    chk("rst_fall", fall_pulse, 2'b00);
    chk("rst_valid", sig_valid, 2'b00);
    chk("rst_glitch", glitch_cnt, 8'h00);
    sys_rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      drive(tbl[v].in, tbl[v].qual);
      for (int k = 0; k < tbl[v].n; k++) tick();
      chk($sformatf("vec%0d_clean", v), wave_clean, tbl[v].clean);
      chk($sformatf("vec%0d_rise", v), rise_pulse, tbl[v].rise);
      chk($sformatf("vec%0d_fall", v), fall_pulse, tbl[v].fall);
      chk($sformatf("vec%0d_valid", v), sig_valid, tbl[v].valid);
      chk($sformatf("vec%0d_glitch", v), glitch_cnt, tbl[v].glitch);
    end

    // Repeated 3-cycle pulses on ch1 drive its glitch count into saturation.
    for (int i = 0; i < 20; i++) begin
      drive(2'b11, 1'b0);
      repeat (3) tick();
      drive(2'b01, 1'b0);
      repeat (4) tick();
      chk($sformatf("glitch_sat%0d", i), glitch_cnt, ((i + 2 > 15) ? 15 : i + 2) << 4);
      chk($sformatf("glitch_clean%0d", i), wave_clean, 2'b01);
    end

    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("clr_stat", glitch_cnt, 8'h00);

    drive(2'b11, 1'b0);
    repeat (3) tick();
    drive(2'b01, 1'b0);
    repeat (2) tick();
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("clr_wins", glitch_cnt, 8'h00);

    drive(2'b11, 1'b0);
    repeat (3) tick();
    drive(2'b01, 1'b0);
    repeat (4) tick();
    chk("glitch_after_clr", glitch_cnt, 8'h10);
    chk("const_high_timeout", sig_valid, 2'b00);

    do_reset();
    t = 0;
    for (int p = 0; p < 5; p++) begin
      drive(2'b11, 1'b1);
      for (int k = 0; k < 10; k++) begin
        tick();
        t++;
        chk("sq_valid", sig_valid, (t >= 6) ? 2'b11 : 2'b00);
      end
      drive(2'b00, 1'b1);
      last_fall = cyc + 6;
      for (int k = 0; k < 10; k++) begin
        tick();
        t++;
        chk("sq_valid", sig_valid, (t >= 6) ? 2'b11 : 2'b00);
      end
    end

    while (cyc < last_fall + 99) tick();
    chk("timeout_minus1", sig_valid, 2'b11);
    tick();
    chk("timeout_exact", sig_valid, 2'b00);

    drive(2'b11, 1'b1);
    repeat (5) tick();
    chk("reedge_pre_valid", sig_valid, 2'b00);
    chk("reedge_pre_clean", wave_clean, 2'b00);
    tick();
    chk("reedge_valid", sig_valid, 2'b11);
    chk("reedge_rise", rise_pulse, 2'b11);
    chk("reedge_clean", wave_clean, 2'b11);

    // Reset lands with ch0's fall two counts into qualification.
    drive(2'b10, 1'b0);
    repeat (4) tick();
    sys_rst = 1'b1;
    #2;
    chk("midrst_clean", wave_clean, 2'b00);
    chk("midrst_valid", sig_valid, 2'b00);
    chk("midrst_rise", rise_pulse, 2'b00);
    chk("midrst_fall", fall_pulse, 2'b00);
    tick();
    sys_rst = 1'b0;
    evq.push_back('{1, cyc + 6, 1'b1});
    repeat (5) tick();
    chk("postrst_pre_clean", wave_clean, 2'b00);
    tick();
    chk("postrst_clean", wave_clean, 2'b10);
    chk("postrst_rise", rise_pulse, 2'b10);
    chk("postrst_valid", sig_valid, 2'b10);

    repeat (8) tick();
    chk("sb_empty", evq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
